// File: rtl/mm_pkg.sv
// Shared matrix-multiply types: scheduler state encoding, buffer instruction
// record and the default width constants used by the buffers and the controller.
package mm_pkg;

   localparam int unsigned MM_N                    = 4;
   localparam int unsigned MM_MEMORY_ADDRESS_BITS  = 64;
   localparam int unsigned MM_MAX_MATRIX_LENGTH    = 4096;
   localparam int unsigned MM_COUNTER_BITS         = $clog2(MM_MAX_MATRIX_LENGTH + 1);
   localparam int unsigned MM_REPEATS_COUNTER_BITS = $clog2(MM_MAX_MATRIX_LENGTH / MM_N + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE_A = 2'd1,
      ISSUE_B = 2'd2,
      FINISH  = 2'd3
   } mm_state_e;

   typedef struct packed {
      logic [MM_MEMORY_ADDRESS_BITS-1:0]  address;
      logic [MM_COUNTER_BITS-1:0]         length;
      logic [MM_REPEATS_COUNTER_BITS-1:0] repeats;
   } mm_instr_t;

endpackage

// File: rtl/tile_instruction_scheduler.sv
// Walks the output tile grid of one GEMM job (row outer, column inner) and issues A/B buffer
// instructions. Optional stall counter output: TILE_INSTRUCTION_SCHEDULER_STALL_COUNT_EN.
module tile_instruction_scheduler
   import mm_pkg::*;
#(
   parameter int unsigned N                    = MM_N,
   parameter int unsigned MEMORY_ADDRESS_BITS  = MM_MEMORY_ADDRESS_BITS,
   parameter int unsigned MAX_MATRIX_LENGTH    = MM_MAX_MATRIX_LENGTH,
   parameter int unsigned COUNTER_BITS         = $clog2(MAX_MATRIX_LENGTH + 1),
   parameter int unsigned REPEATS_COUNTER_BITS = $clog2(MAX_MATRIX_LENGTH / N + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            job_valid,
   output logic                            job_ready,
   input  logic [MEMORY_ADDRESS_BITS-1:0]  job_a_base,
   input  logic [MEMORY_ADDRESS_BITS-1:0]  job_b_base,
   input  logic [COUNTER_BITS-1:0]         job_k_length,
   input  logic [REPEATS_COUNTER_BITS-1:0] job_row_tiles,
   input  logic [REPEATS_COUNTER_BITS-1:0] job_col_tiles,
   output logic                            a_instruction_valid,
   input  logic                            a_instruction_ready,
   output logic [MEMORY_ADDRESS_BITS-1:0]  a_address,
   output logic [COUNTER_BITS-1:0]         a_length,
   output logic [REPEATS_COUNTER_BITS-1:0] a_repeats,
   output logic                            b_instruction_valid,
   input  logic                            b_instruction_ready,
   output logic [MEMORY_ADDRESS_BITS-1:0]  b_address,
   output logic [COUNTER_BITS-1:0]         b_length,
   output logic [REPEATS_COUNTER_BITS-1:0] b_repeats,
   output logic                            busy,
   output logic                            job_done
`ifdef TILE_INSTRUCTION_SCHEDULER_STALL_COUNT_EN
   ,
   output logic [31:0]                     stall_cycles
`endif
);

   mm_state_e                         state_q, state_d;
   mm_instr_t                         a_instr_q, a_instr_d;
   mm_instr_t                         b_instr_q, b_instr_d;
   logic [MEMORY_ADDRESS_BITS-1:0]    stride_q, stride_d;
   logic [MEMORY_ADDRESS_BITS-1:0]    b_base_q, b_base_d;
   logic [REPEATS_COUNTER_BITS-1:0]   row_tiles_q, row_tiles_d;
   logic [REPEATS_COUNTER_BITS-1:0]   row_idx_q, row_idx_d;
   logic [REPEATS_COUNTER_BITS-1:0]   col_idx_q, col_idx_d;
   logic                              a_vld_q, a_vld_d;
   logic                              b_vld_q, b_vld_d;
   logic                              busy_q, busy_d;
   logic                              done_q, done_d;
   logic                              ready_q, ready_d;
   logic                              capture;
   logic                              degenerate;
   logic                              last_col;
   logic                              last_row;

   assign capture    = (state_q == IDLE) && job_valid && ready_q;
   assign degenerate = (job_k_length == '0) || (job_row_tiles == '0) || (job_col_tiles == '0);
   // a_instr_q.repeats doubles as the latched column-tile count.
   assign last_col   = (col_idx_q == a_instr_q.repeats - REPEATS_COUNTER_BITS'(1));
   assign last_row   = (row_idx_q == row_tiles_q - REPEATS_COUNTER_BITS'(1));

   always_comb begin
      state_d     = state_q;
      a_instr_d   = a_instr_q;
      b_instr_d   = b_instr_q;
      stride_d    = stride_q;
      b_base_d    = b_base_q;
      row_tiles_d = row_tiles_q;
      row_idx_d   = row_idx_q;
      col_idx_d   = col_idx_q;
      a_vld_d     = a_vld_q;
      b_vld_d     = b_vld_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ready_d     = ready_q;
      case (state_q)
         IDLE: begin
            if (capture) begin
               a_instr_d.address = job_a_base;
               a_instr_d.length  = job_k_length;
               a_instr_d.repeats = job_col_tiles;
               b_instr_d.address = job_b_base;
               b_instr_d.length  = job_k_length;
               b_instr_d.repeats = REPEATS_COUNTER_BITS'(1);
               stride_d          = MEMORY_ADDRESS_BITS'(job_k_length) * MEMORY_ADDRESS_BITS'(N);
               b_base_d          = job_b_base;
               row_tiles_d       = job_row_tiles;
               row_idx_d         = '0;
               col_idx_d         = '0;
               busy_d            = 1'b1;
               ready_d           = 1'b0;
               if (degenerate) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d = ISSUE_A;
                  a_vld_d = 1'b1;
               end
            end
         end
         ISSUE_A: begin
            if (a_instruction_ready) begin
               a_vld_d = 1'b0;
               b_vld_d = 1'b1;
               state_d = ISSUE_B;
            end
         end
         ISSUE_B: begin
            if (b_instruction_ready) begin
               if (!last_col) begin
                  col_idx_d         = col_idx_q + REPEATS_COUNTER_BITS'(1);
                  b_instr_d.address = b_instr_q.address + stride_q;
               end else if (last_row) begin
                  b_vld_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = FINISH;
               end else begin
                  // Next row-tile: A advances one stride, B rewinds to the first column.
                  b_vld_d           = 1'b0;
                  a_vld_d           = 1'b1;
                  row_idx_d         = row_idx_q + REPEATS_COUNTER_BITS'(1);
                  col_idx_d         = '0;
                  a_instr_d.address = a_instr_q.address + stride_q;
                  b_instr_d.address = b_base_q;
                  state_d           = ISSUE_A;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         a_instr_q   <= '0;
         b_instr_q   <= '0;
         stride_q    <= '0;
         b_base_q    <= '0;
         row_tiles_q <= '0;
         row_idx_q   <= '0;
         col_idx_q   <= '0;
         a_vld_q     <= 1'b0;
         b_vld_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_instr_q   <= a_instr_d;
         b_instr_q   <= b_instr_d;
         stride_q    <= stride_d;
         b_base_q    <= b_base_d;
         row_tiles_q <= row_tiles_d;
         row_idx_q   <= row_idx_d;
         col_idx_q   <= col_idx_d;
         a_vld_q     <= a_vld_d;
         b_vld_q     <= b_vld_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ready_q     <= ready_d;
      end
   end

   assign job_ready           = ready_q;
   assign busy                = busy_q;
   assign job_done            = done_q;
   assign a_instruction_valid = a_vld_q;
   assign a_address           = a_instr_q.address;
   assign a_length            = a_instr_q.length;
   assign a_repeats           = a_instr_q.repeats;
   assign b_instruction_valid = b_vld_q;
   assign b_address           = b_instr_q.address;
   assign b_length            = b_instr_q.length;
   assign b_repeats           = b_instr_q.repeats;

`ifdef TILE_INSTRUCTION_SCHEDULER_STALL_COUNT_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (capture) begin
         stall_d = '0;
      end else if (((a_vld_q && !a_instruction_ready) || (b_vld_q && !b_instruction_ready))
                   && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_tile_instruction_scheduler.sv
// Directed bench for tile_instruction_scheduler: nominal, backpressure, degenerate, queued job,
// mid-job reset and (with TILE_INSTRUCTION_SCHEDULER_STALL_COUNT_EN) the stall counter.
module tb_tile_instruction_scheduler;

   typedef logic [87:0] ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        job_valid;
   logic        job_ready;
   logic [63:0] job_a_base, job_b_base;
   logic [12:0] job_k_length;
   logic [10:0] job_row_tiles, job_col_tiles;
   logic        a_instruction_valid, a_instruction_ready;
   logic [63:0] a_address;
   logic [12:0] a_length;
   logic [10:0] a_repeats;
   logic        b_instruction_valid, b_instruction_ready;
   logic [63:0] b_address;
   logic [12:0] b_length;
   logic [10:0] b_repeats;
   logic        busy, job_done;
`ifdef TILE_INSTRUCTION_SCHEDULER_STALL_COUNT_EN
   logic [31:0] stall_cycles;
`endif

   int   checks = 0;
   int   errors = 0;
   ent_t a_got[$];
   ent_t b_got[$];
   int   done_cnt, done_cyc, vld_seen, wait_cycles;

   tile_instruction_scheduler dut (
      .clk                 (clk),
      .reset               (reset),
      .job_valid           (job_valid),
      .job_ready           (job_ready),
      .job_a_base          (job_a_base),
      .job_b_base          (job_b_base),
      .job_k_length        (job_k_length),
      .job_row_tiles       (job_row_tiles),
      .job_col_tiles       (job_col_tiles),
      .a_instruction_valid (a_instruction_valid),
      .a_instruction_ready (a_instruction_ready),
      .a_address           (a_address),
      .a_length            (a_length),
      .a_repeats           (a_repeats),
      .b_instruction_valid (b_instruction_valid),
      .b_instruction_ready (b_instruction_ready),
      .b_address           (b_address),
      .b_length            (b_length),
      .b_repeats           (b_repeats),
      .busy                (busy),
      .job_done            (job_done)
`ifdef TILE_INSTRUCTION_SCHEDULER_STALL_COUNT_EN
      ,
      .stall_cycles        (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Presents a job, waits for acceptance, then runs until job_done while recording handshakes.
   // mode 0: readies high; 1: a_ready low 5 cycles, b_ready random; 2: b_ready low 7 cycles on
   // the first B; 3: readies high and a second job is presented while busy.
   task automatic run_job(input logic [63:0] ab, input logic [63:0] bb, input logic [12:0] k,
                          input logic [10:0] rt, input logic [10:0] ct, input int mode);
      int   c;
      bit   done, a_pend, b_pend;
      ent_t a_prev, b_prev;
      a_got.delete();
      b_got.delete();
      done_cnt = 0; done_cyc = -1; vld_seen = 0; wait_cycles = 0;
      @(negedge clk);
      job_a_base = ab; job_b_base = bb; job_k_length = k;
      job_row_tiles = rt; job_col_tiles = ct; job_valid = 1'b1;
      a_instruction_ready = 1'b1; b_instruction_ready = 1'b1;
      while (!job_ready && wait_cycles < 100) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (!job_ready) check("job_accept_timeout", job_ready, 1'b1);
      c = 0; done = 0; a_pend = 0; b_pend = 0; a_prev = '0; b_prev = '0;
      while (!done && c < 300) begin
         @(negedge clk);
         c++;
         if (c == 1) job_valid = 1'b0;
         case (mode)
            1: begin
               a_instruction_ready = (c > 5);
               b_instruction_ready = 1'($urandom_range(0, 1));
            end
            2: begin
               a_instruction_ready = 1'b1;
               b_instruction_ready = !(c >= 2 && c <= 8);
            end
            default: begin
               a_instruction_ready = 1'b1;
               b_instruction_ready = 1'b1;
            end
         endcase
         if (mode == 3 && c == 3) begin
            job_a_base = 64'hFFFF_FFFF_FFFF_FFF0; job_b_base = 64'hFFFF_FFFF_FFFF_FFE0;
            job_k_length = 13'd4; job_row_tiles = 11'd2; job_col_tiles = 11'd2;
            job_valid = 1'b1;
            check("ready_low_while_busy", job_ready, 1'b0);
         end
         if (a_pend) begin
            check("a_hold_valid", a_instruction_valid, 1'b1);
            check("a_hold_payload", {a_address, a_length, a_repeats}, a_prev);
         end
         if (b_pend) begin
            check("b_hold_valid", b_instruction_valid, 1'b1);
            check("b_hold_payload", {b_address, b_length, b_repeats}, b_prev);
         end
         if (a_instruction_valid) vld_seen++;
         if (b_instruction_valid) vld_seen++;
         if (a_instruction_valid && a_instruction_ready) a_got.push_back({a_address, a_length, a_repeats});
         if (b_instruction_valid && b_instruction_ready) b_got.push_back({b_address, b_length, b_repeats});
         a_pend = a_instruction_valid && !a_instruction_ready;
         b_pend = b_instruction_valid && !b_instruction_ready;
         a_prev = {a_address, a_length, a_repeats};
         b_prev = {b_address, b_length, b_repeats};
         if (job_done) begin
            done_cnt++;
            done_cyc = c;
            done = 1;
            check("ready_low_at_done", job_ready, 1'b0);
         end
      end
      if (!done) check("job_done_timeout", done, 1'b1);
   endtask

   // Expected streams built from the job fields with a multiply per position.
   task automatic expect_stream(input string tag, input logic [63:0] ab, input logic [63:0] bb,
                                input logic [12:0] k, input logic [10:0] rt, input logic [10:0] ct);
      logic [63:0] stride;
      int          n_a, n_b, bi;
      stride = 64'(k) * 64'd4;
      n_a = (k == 0 || rt == 0 || ct == 0) ? 0 : int'(rt);
      n_b = n_a * int'(ct);
      check({tag, "_a_count"}, a_got.size(), n_a);
      check({tag, "_b_count"}, b_got.size(), n_b);
      bi = 0;
      for (int r = 0; r < n_a; r++) begin
         if (r < a_got.size())
            check({tag, "_a_instr"}, a_got[r], {ab + 64'(r) * stride, k, ct});
         for (int c = 0; c < int'(ct); c++) begin
            if (bi < b_got.size())
               check({tag, "_b_instr"}, b_got[bi], {bb + 64'(c) * stride, k, 11'd1});
            bi++;
         end
      end
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse_one_cycle"}, job_done, 1'b0);
      check({tag, "_idle_valids"}, {a_instruction_valid, b_instruction_valid}, 2'b00);
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_idle_ready"}, job_ready, 1'b1);
   endtask

   initial begin
      reset = 1'b0; job_valid = 1'b0;
      job_a_base = '0; job_b_base = '0; job_k_length = '0;
      job_row_tiles = '0; job_col_tiles = '0;
      a_instruction_ready = 1'b0; b_instruction_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valids", {a_instruction_valid, b_instruction_valid}, 2'b00);
      check("rst_busy_done", {busy, job_done}, 2'b00);
      check("rst_addresses", {a_address, b_address}, 128'd0);
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_ready", job_ready, 1'b1);

      run_job(64'h1000, 64'h2000, 13'd8, 11'd2, 11'd3, 0);
      expect_stream("nom", 64'h1000, 64'h2000, 13'd8, 11'd2, 11'd3);
      check("nom_done_count", done_cnt, 1);
      check("nom_done_cycle", done_cyc, 9);
      idle_check("nom");

      run_job(64'h1000, 64'h2000, 13'd8, 11'd2, 11'd3, 1);
      expect_stream("bp", 64'h1000, 64'h2000, 13'd8, 11'd2, 11'd3);
      check("bp_done_count", done_cnt, 1);
      idle_check("bp");

      run_job(64'h3000, 64'h4000, 13'd0, 11'd2, 11'd3, 0);
      check("deg_k_valids", vld_seen, 0);
      check("deg_k_done_cycle", done_cyc, 1);
      idle_check("deg_k");
      run_job(64'h3000, 64'h4000, 13'd8, 11'd0, 11'd3, 0);
      check("deg_rows_valids", vld_seen, 0);
      check("deg_rows_done_cycle", done_cyc, 1);
      idle_check("deg_rows");
      run_job(64'h3000, 64'h4000, 13'd8, 11'd2, 11'd0, 0);
      check("deg_cols_valids", vld_seen, 0);
      check("deg_cols_done_cycle", done_cyc, 1);
      idle_check("deg_cols");

      run_job(64'h1000, 64'h2000, 13'd8, 11'd2, 11'd3, 3);
      expect_stream("job1", 64'h1000, 64'h2000, 13'd8, 11'd2, 11'd3);
      run_job(64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFE0, 13'd4, 11'd2, 11'd2, 0);
      check("job2_no_wait", wait_cycles, 0);
      expect_stream("job2_wrap", 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFE0, 13'd4, 11'd2, 11'd2);
      idle_check("job2");

      @(negedge clk);
      job_a_base = 64'h5000; job_b_base = 64'h6000; job_k_length = 13'd8;
      job_row_tiles = 11'd2; job_col_tiles = 11'd3; job_valid = 1'b1;
      a_instruction_ready = 1'b1; b_instruction_ready = 1'b0;
      @(negedge clk);
      job_valid = 1'b0;
      @(negedge clk);
      check("mid_b_valid", b_instruction_valid, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("async_rst_valids", {a_instruction_valid, b_instruction_valid}, 2'b00);
      check("async_rst_busy_done", {busy, job_done}, 2'b00);
      check("async_rst_addr", b_address, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rel_ready", job_ready, 1'b1);
      check("rel_no_valid", {a_instruction_valid, b_instruction_valid}, 2'b00);
      run_job(64'h7000, 64'h8000, 13'd4, 11'd1, 11'd2, 0);
      expect_stream("after_rst", 64'h7000, 64'h8000, 13'd4, 11'd1, 11'd2);
      idle_check("after_rst");

`ifdef TILE_INSTRUCTION_SCHEDULER_STALL_COUNT_EN
      run_job(64'h1000, 64'h2000, 13'd8, 11'd1, 11'd2, 2);
      expect_stream("stall", 64'h1000, 64'h2000, 13'd8, 11'd1, 11'd2);
      check("stall_count", stall_cycles, 32'd7);
      run_job(64'h1000, 64'h2000, 13'd8, 11'd1, 11'd2, 0);
      check("stall_cleared", stall_cycles, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
